umi_memtest_host: RTL and testbench
===================================

Name: umi_memtest_host

Overview:
- UMI host-side (initiator) traffic generator and checker; the requester counterpart to the multi-port RAM device endpoint.
- Issues a programmed burst of 64-bit writes followed by matching reads over one UMI host port.
- Checks every read response against a regenerated pattern and reports pass/fail plus error count.
- Used for RAM bring-up, fabric soak tests and as a bench stimulus block.

Parameters:
- DW, 256, UMI data width (>=64)
- AW, 64, UMI address width
- CW, 32, UMI command width
- CNTW, 16, width of transfer count
- MAXOUT, 4, max outstanding requests without response (1..15)

Ports:
- clk  input  1  clock
- nreset  input  1  async active-low reset
- go  input  1  start pulse; ignored while busy
- base_addr  input  AW  first target address (8-byte aligned)
- count  input  CNTW  number of words; 0 = finish immediately
- seed  input  64  pattern seed
- host_addr  input  AW  driven on srcaddr; responses return to it
- busy  output  1  test in progress
- done  output  1  one-cycle pulse at completion
- fail  output  1  sticky, set on any mismatch or bad response opcode
- errcount  output  CNTW  saturating error count
- uhost_req_valid  output  1  request valid
- uhost_req_cmd  output  CW  request command
- uhost_req_dstaddr  output  AW  request address
- uhost_req_srcaddr  output  AW  = host_addr
- uhost_req_data  output  DW  write data, pattern in [63:0], upper bits 0
- uhost_req_ready  input  1  request ready
- uhost_resp_valid  input  1  response valid
- uhost_resp_cmd  input  CW  response command
- uhost_resp_dstaddr  input  AW  unused except lint
- uhost_resp_srcaddr  input  AW  unused
- uhost_resp_data  input  DW  read data
- uhost_resp_ready  output  1  response ready

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on nreset.
- Reset values: all outputs 0, FSM in IDLE, all counters 0. uhost_resp_ready is 0 in IDLE and 1 otherwise.
- Pattern: P(i) = seed ^ {~i[31:0], i[31:0]}, i zero-extended. Word i targets address base_addr + 8*i, modulo 2^AW with silent wrap.
- Command fields: opcode cmd[4:0], size cmd[7:5]=3, len cmd[15:8]=0, eom cmd[22]=1, all other bits 0.
- Opcodes: REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, RESP_READ=0x02, RESP_WRITE=0x04.
- FSM states IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
  - IDLE: on go, latch base_addr/count/seed, clear fail/errcount/indices. Go to WRITE, or straight to DONE if count=0.
  - WRITE: present write i. Advance i on valid&ready. After the last accept, go to WDRAIN.
  - WDRAIN: wait until outstanding=0, then reset i and go to READ.
  - READ: issue reads the same way as writes. After the last accept, go to RDRAIN.
  - RDRAIN: wait until every read response has arrived (rcv index = count), then go to DONE.
  - DONE: pulse done for one cycle, return to IDLE.
- busy is 1 in every state except IDLE.
- Outstanding counter: +1 on request accept, -1 on response accept; both on the same cycle leaves it unchanged.
- uhost_req_valid is gated off while outstanding = MAXOUT.
- Once valid is asserted, cmd/addr/data stay stable until ready.
- Responses are in order. The j-th RESP_READ is compared as uhost_resp_data[63:0] vs P(j); on mismatch set fail and increment errcount.
- Opcode check: in write phases, any response other than RESP_WRITE is an error. In read phases, any response other than RESP_READ is an error.
- errcount saturates at all-ones.
- A response arriving in IDLE is not accepted (ready=0).
- go during busy is ignored.
- Reset mid-test aborts immediately: valid drops, no done pulse.

Optional Feature:
- Macro UMI_MEMTEST_POSTED_EN.
- Defined: writes use REQ_POSTED and are not counted as outstanding. WDRAIN exits the cycle after the final write accept. Any response during the write phase is flagged as an error.
- Undefined: writes use REQ_WRITE and each expects a RESP_WRITE, as described above.

Test Plan:
- Basic pass: count=4, base=0x100, seed=0, ideal RAM. Expect writes to 0x100/0x108/0x110/0x118 with data 0xFFFFFFFF_00000000, 0xFFFFFFFE_00000001, ..., then 4 reads. Expect done pulse, fail=0, errcount=0.
- Corruption: RAM model flips bit 0 of word 2 on read, count=4, seed=0x5A5A. Expect fail=1, errcount=1.
- Backpressure: uhost_req_ready toggles 1-in-3 and responses are delayed 10 cycles, MAXOUT=4. Expect never more than 4 outstanding, request fields stable while stalled, pass result.
- Zero count: go with count=0. Expect no requests and done asserted 2 cycles after go.
- Reset abort: assert nreset low during READ with count=8. Expect all outputs 0 and no done; a new go afterward gives a clean pass.
- Bad opcode: model returns RESP_WRITE for the first read. Expect fail=1, errcount=1, test still completes.

Source files
------------

// File: rtl/umi_memtest_host_if.sv
// UMI host port bundle used by umi_memtest_host.
// master: the initiator side (drives requests, accepts responses).
// slave:  the device side (accepts requests, drives responses).
interface umi_memtest_host_if #(
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32
) ();
    logic          req_valid;
    logic [CW-1:0] req_cmd;
    logic [AW-1:0] req_dstaddr;
    logic [AW-1:0] req_srcaddr;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          resp_valid;
    logic [CW-1:0] resp_cmd;
    logic [AW-1:0] resp_dstaddr;
    logic [AW-1:0] resp_srcaddr;
    logic [DW-1:0] resp_data;
    logic          resp_ready;

    modport master (
        output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
    );

    modport slave (
        input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
        output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
    );
endinterface

// File: rtl/umi_memtest_host.sv
// UMI memory test initiator: writes a seeded 64-bit pattern to count words
// starting at base_addr, reads them back in order and checks every response.
// Optional macro UMI_MEMTEST_POSTED_EN: writes go out as posted requests that
// expect no response; any response during the write phase is an error.
module umi_memtest_host #(
    parameter int DW     = 256,
    parameter int AW     = 64,
    parameter int CW     = 32,
    parameter int CNTW   = 16,
    parameter int MAXOUT = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                go,
    input  logic [AW-1:0]       base_addr,
    input  logic [CNTW-1:0]     count,
    input  logic [63:0]         seed,
    input  logic [AW-1:0]       host_addr,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [CNTW-1:0]     errcount,
    umi_memtest_host_if.master  uhost
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WDRAIN = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_RDRAIN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

`ifdef UMI_MEMTEST_POSTED_EN
    localparam logic [4:0] WR_OPC     = REQ_POSTED;
    localparam logic       WR_COUNTED = 1'b0;
`else
    localparam logic [4:0] WR_OPC     = REQ_WRITE;
    localparam logic       WR_COUNTED = 1'b1;
`endif

    // Outstanding counter width: MAXOUT is at most 15.
    localparam int OW = 4;

    logic [2:0]      state_reg, state_next;
    logic [CNTW-1:0] idx_reg, rcv_reg, cnt_reg, err_reg;
    logic [AW-1:0]   base_reg;
    logic [63:0]     seed_reg;
    logic [OW-1:0]   out_reg;
    logic            fail_reg, done_reg;

    logic            wr_phase, rd_phase, req_phase;
    logic            req_fire, resp_fire, req_last;
    logic            out_inc, out_dec, resp_err;
    logic [4:0]      req_opc, resp_opc;
    logic            unused_bits;

    // Word i carries seed ^ {~i, i} with i zero-extended to 32 bits.
    function automatic logic [63:0] pattern(input logic [63:0] s, input logic [CNTW-1:0] i);
        logic [31:0] i32;
        i32 = 32'(i);
        return s ^ {~i32, i32};
    endfunction

    assign wr_phase  = (state_reg == S_WRITE) || (state_reg == S_WDRAIN);
    assign rd_phase  = (state_reg == S_READ)  || (state_reg == S_RDRAIN);
    assign req_phase = (state_reg == S_WRITE) || (state_reg == S_READ);
    assign req_opc   = (state_reg == S_READ) ? REQ_READ : WR_OPC;
    assign resp_opc  = uhost.resp_cmd[4:0];

    // Valid can only fall by being accepted: while a request waits, the
    // outstanding count never rises, so the MAXOUT gate cannot drop it.
    assign uhost.req_valid   = req_phase && (out_reg != OW'(MAXOUT));
    assign uhost.req_cmd     = req_phase ? CW'({1'b1, 6'b0, 8'h00, 3'd3, req_opc}) : '0;
    assign uhost.req_dstaddr = req_phase ? base_reg + AW'({idx_reg, 3'b000}) : '0;
    assign uhost.req_srcaddr = req_phase ? host_addr : '0;
    assign uhost.req_data    = req_phase ? DW'(pattern(seed_reg, idx_reg)) : '0;
    assign uhost.resp_ready  = (state_reg != S_IDLE);

    assign req_fire  = uhost.req_valid && uhost.req_ready;
    assign resp_fire = uhost.resp_valid && uhost.resp_ready;
    assign req_last  = (idx_reg == cnt_reg - CNTW'(1));
    assign out_inc   = req_fire && ((state_reg == S_READ) || WR_COUNTED);
    assign out_dec   = resp_fire && (out_reg != '0);

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign fail     = fail_reg;
    assign errcount = err_reg;

    // Response fields that carry no information for this checker.
    assign unused_bits = ^{uhost.resp_dstaddr, uhost.resp_srcaddr,
                           uhost.resp_cmd[CW-1:5], uhost.resp_data[DW-1:64]};

    // Classify an accepted response as good or bad for the current phase.
    always_comb begin
        resp_err = 1'b0;
        if (wr_phase) begin
`ifdef UMI_MEMTEST_POSTED_EN
            resp_err = 1'b1;
`else
            resp_err = (resp_opc != RESP_WRITE);
`endif
        end else if (rd_phase) begin
            resp_err = (resp_opc != RESP_READ) ||
                       (uhost.resp_data[63:0] != pattern(seed_reg, rcv_reg));
        end
    end

    // Next-state logic for the write/drain/read/drain sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (go) state_next = (count == '0) ? S_DONE : S_WRITE;
            S_WRITE:  if (req_fire && req_last) state_next = S_WDRAIN;
            S_WDRAIN: if (out_reg == '0) state_next = S_READ;
            S_READ:   if (req_fire && req_last) state_next = S_RDRAIN;
            S_RDRAIN: if (rcv_reg == cnt_reg) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register and the registered completion pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == S_DONE);
        end
    end

    // Test configuration latched on an accepted go.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            base_reg <= '0;
            cnt_reg  <= '0;
            seed_reg <= '0;
        end else if ((state_reg == S_IDLE) && go) begin
            base_reg <= base_addr;
            cnt_reg  <= count;
            seed_reg <= seed;
        end
    end

    // Request index (advances per accept) and response index (per read response).
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx_reg <= '0;
            rcv_reg <= '0;
        end else if ((state_reg == S_IDLE) && go) begin
            idx_reg <= '0;
            rcv_reg <= '0;
        end else begin
            if (state_reg == S_WDRAIN)
                idx_reg <= '0;
            else if (req_fire)
                idx_reg <= idx_reg + CNTW'(1);
            if (resp_fire && rd_phase)
                rcv_reg <= rcv_reg + CNTW'(1);
        end
    end

    // Requests in flight without a response.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            out_reg <= '0;
        else if (out_inc && !out_dec)
            out_reg <= out_reg + OW'(1);
        else if (!out_inc && out_dec)
            out_reg <= out_reg - OW'(1);
    end

    // Sticky fail flag and saturating error count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fail_reg <= 1'b0;
            err_reg  <= '0;
        end else if ((state_reg == S_IDLE) && go) begin
            fail_reg <= 1'b0;
            err_reg  <= '0;
        end else if (resp_fire && resp_err) begin
            fail_reg <= 1'b1;
            if (err_reg != '1)
                err_reg <= err_reg + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_umi_memtest_host.sv
// Bench for umi_memtest_host: a RAM model answers requests, a scoreboard
// queue holds the expected request stream, and a vector table drives runs.
module tb_umi_memtest_host;
    localparam int DW = 256, AW = 64, CW = 32, CNTW = 16, MAXOUT = 4;

`ifdef UMI_MEMTEST_POSTED_EN
    localparam logic [4:0] WR_OPC = 5'h05;
`else
    localparam logic [4:0] WR_OPC = 5'h03;
`endif

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            go = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [CNTW-1:0] count = '0;
    logic [63:0]     seed = '0;
    logic [AW-1:0]   host_addr = 64'h0000_00AB_CD00_0000;
    logic            busy, done, fail;
    logic [CNTW-1:0] errcount;

    umi_memtest_host_if #(.DW(DW), .AW(AW), .CW(CW)) uhost ();

    umi_memtest_host #(.DW(DW), .AW(AW), .CW(CW), .CNTW(CNTW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .nreset(nreset), .go(go), .base_addr(base_addr), .count(count),
        .seed(seed), .host_addr(host_addr), .busy(busy), .done(done), .fail(fail),
        .errcount(errcount), .uhost(uhost)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [CW-1:0] cmd; logic [63:0] addr; logic [63:0] data; } req_t;
    typedef struct { logic [CW-1:0] cmd; logic [63:0] data; int rdy; } rsp_t;
    typedef struct {
        string name; int cnt; logic [63:0] base; logic [63:0] seed;
        int corrupt; int badop; bit bp; int dly; bit regoo; bit exp_fail; int exp_err;
    } vec_t;

    int checks = 0, errors = 0;
    req_t exp_q[$];
    rsp_t rsp_q[$];
    logic [63:0] mem [bit [63:0]];

    // model configuration and state
    int   cyc = 0, dly = 1, corrupt = -1, badop = -1, rd_num = 0, wr_num = 0;
    int   out_b = 0, max_out = 0;
    bit   bp = 1'b0, pend = 1'b0;
    logic [CW-1:0] hold_cmd;
    logic [63:0]   hold_addr, hold_data, first_wdata;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [63:0] s, input int i);
        logic [31:0] i32;
        i32 = i;
        return s ^ {~i32, i32};
    endfunction

    function automatic logic [CW-1:0] mkcmd(input logic [4:0] opc);
        return CW'(opc) | (CW'(3) << 5) | (CW'(1) << 22);
    endfunction

    // RAM model: decides each upcoming handshake on the falling edge.
    initial begin : model
        req_t e;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                chk("stall_valid", uhost.req_valid, 1'b1);
                chk("stall_fields", {uhost.req_cmd, uhost.req_dstaddr, uhost.req_data[63:0]},
                    {hold_cmd, hold_addr, hold_data});
                pend = 1'b0;
            end
            uhost.req_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (rsp_q.size() != 0 && rsp_q[0].rdy <= cyc) begin
                uhost.resp_valid = 1'b1;
                uhost.resp_cmd   = rsp_q[0].cmd;
                uhost.resp_data  = {{(DW-64){1'b1}}, rsp_q[0].data};
            end else begin
                uhost.resp_valid = 1'b0;
                uhost.resp_cmd   = '0;
                uhost.resp_data  = '0;
            end
            if (nreset && uhost.req_valid && !uhost.req_ready) begin
                pend      = 1'b1;
                hold_cmd  = uhost.req_cmd;
                hold_addr = uhost.req_dstaddr;
                hold_data = uhost.req_data[63:0];
            end
            if (nreset && uhost.resp_valid && uhost.resp_ready) begin
                void'(rsp_q.pop_front());
                out_b--;
            end
            if (nreset && uhost.req_valid && uhost.req_ready) begin
                $display("REQ cyc=%0d cmd=%0h addr=%0h data=%0h", cyc, uhost.req_cmd,
                         uhost.req_dstaddr, uhost.req_data[63:0]);
                if (exp_q.size() == 0) begin
                    chk("req_extra", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_cmd", uhost.req_cmd, e.cmd);
                    chk("req_addr", uhost.req_dstaddr, e.addr);
                    chk("req_src", uhost.req_srcaddr, host_addr);
                    if (e.wr) begin
                        chk("req_wdata", uhost.req_data, {{(DW-64){1'b0}}, e.data});
                        if (wr_num == 0) first_wdata = uhost.req_data[63:0];
                        wr_num++;
                        mem[e.addr] = uhost.req_data[63:0];
`ifndef UMI_MEMTEST_POSTED_EN
                        rsp_q.push_back('{cmd: CW'(5'h04), data: 64'h0, rdy: cyc + dly});
                        out_b++;
`endif
                    end else begin
                        d = mem.exists(e.addr) ? mem[e.addr] : 64'h0;
                        if (rd_num == corrupt) d = d ^ 64'h1;
                        rsp_q.push_back('{cmd: CW'((rd_num == badop) ? 5'h04 : 5'h02),
                                          data: d, rdy: cyc + dly});
                        rd_num++;
                        out_b++;
                    end
                    if (out_b > max_out) max_out = out_b;
                end
            end
        end
    end

    task automatic start_vec(input vec_t v);
        exp_q.delete();
        for (int i = 0; i < v.cnt; i++)
            exp_q.push_back('{wr: 1'b1, cmd: mkcmd(WR_OPC), addr: v.base + 64'(8 * i), data: pat(v.seed, i)});
        for (int i = 0; i < v.cnt; i++)
            exp_q.push_back('{wr: 1'b0, cmd: mkcmd(5'h01), addr: v.base + 64'(8 * i), data: 64'h0});
        bp = v.bp; dly = v.dly; corrupt = v.corrupt; badop = v.badop;
        rd_num = 0; wr_num = 0; out_b = 0; max_out = 0;
        @(negedge clk);
        base_addr = v.base; count = CNTW'(v.cnt); seed = v.seed; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        seen = 1'b0;
        start_vec(v);
        for (int c = 0; c < 4000; c++) begin
            if (done) begin seen = 1'b1; break; end
            if (v.regoo && c == 3) begin count = 16'd100; base_addr = '0; go = 1'b1; end
            if (v.regoo && c == 4) go = 1'b0;
            @(negedge clk);
        end
        chk({v.name, "_done_seen"}, seen, 1'b1);
        chk({v.name, "_fail"}, fail, v.exp_fail);
        chk({v.name, "_errcount"}, errcount, CNTW'(v.exp_err));
        chk({v.name, "_busy_at_done"}, busy, 1'b0);
        chk({v.name, "_reqs_left"}, exp_q.size(), 0);
        chk({v.name, "_max_out_ok"}, max_out <= MAXOUT, 1'b1);
        @(negedge clk);
        chk({v.name, "_done_pulse"}, done, 1'b0);
        $display("RUN %s cnt=%0d fail=%0d errcount=%0d max_out=%0d", v.name, v.cnt, fail, errcount, max_out);
    endtask

    vec_t vecs[6];
    vec_t abort_v;

    initial begin : main
        uhost.req_ready = 1'b0; uhost.resp_valid = 1'b0; uhost.resp_cmd = '0;
        uhost.resp_dstaddr = '0; uhost.resp_srcaddr = '0; uhost.resp_data = '0;
        vecs[0] = '{"basic",   4, 64'h100, 64'h0, -1, -1, 1'b0, 1, 1'b1, 1'b0, 0};
        vecs[1] = '{"corrupt", 4, 64'h200, 64'h5A5A, 2, -1, 1'b0, 1, 1'b0, 1'b1, 1};
        vecs[2] = '{"backpr", 12, 64'h1000, 64'h1234_5678_9ABC_DEF0, -1, -1, 1'b1, 10, 1'b0, 1'b0, 0};
        vecs[3] = '{"badop",   4, 64'h300, 64'hDEAD, -1, 0, 1'b0, 1, 1'b0, 1'b1, 1};
        vecs[4] = '{"wrap",    4, 64'hFFFF_FFFF_FFFF_FFF0, 64'hA5A5_0F0F_3C3C_9669, -1, -1, 1'b0, 2, 1'b0, 1'b0, 0};
        vecs[5] = '{"twoerr",  6, 64'h4000, 64'h77, 1, 4, 1'b0, 3, 1'b0, 1'b1, 2};
        abort_v = '{"abort",   8, 64'h800, 64'hC0FFEE, 0, -1, 1'b0, 1, 1'b0, 1'b0, 0};

        // reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_errcount", errcount, '0);
        chk("rst_req_valid", uhost.req_valid, 1'b0);
        chk("rst_req_fields", {uhost.req_cmd, uhost.req_dstaddr, uhost.req_srcaddr, uhost.req_data[63:0]}, '0);
        chk("rst_resp_ready", uhost.resp_ready, 1'b0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("idle_resp_ready", uhost.resp_ready, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
            if (k == 0) chk("basic_first_wdata", first_wdata, 64'hFFFF_FFFF_0000_0000);
        end

        // zero count: no requests, done two cycles after go
        exp_q.delete(); wr_num = 0; rd_num = 0; bp = 1'b0;
        base_addr = 64'h900; count = '0; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("zero_done_c1", done, 1'b0);
        chk("zero_busy_c1", busy, 1'b1);
        @(negedge clk);
        chk("zero_done_c2", done, 1'b1);
        chk("zero_busy_c2", busy, 1'b0);
        chk("zero_no_reqs", wr_num + rd_num, 0);
        @(negedge clk);
        chk("zero_done_pulse", done, 1'b0);

        // reset abort in the read phase (first read corrupted so fail is set)
        start_vec(abort_v);
        for (int c = 0; c < 2000 && rd_num < 3; c++) @(negedge clk);
        chk("abort_in_read", rd_num >= 3, 1'b1);
        chk("abort_pre_fail", fail, 1'b1);
        @(posedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_fail", fail, 1'b0);
        chk("abort_errcount", errcount, '0);
        chk("abort_req_valid", uhost.req_valid, 1'b0);
        chk("abort_resp_ready", uhost.resp_ready, 1'b0);
        exp_q.delete(); rsp_q.delete(); pend = 1'b0; out_b = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        nreset = 1'b1;
        abort_v.corrupt = -1;
        abort_v.name = "after_abort";
        run_vec(abort_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
